inst_memory: RTL and testbench

Instruction-memory responder serving the core's fetch stage. Answers fetch read requests with one-cycle registered latency, and owns the program-load path: a byte stream from the UART receiver is assembled into 32-bit big-endian words and written sequentially from word address 0. While a load is in progress the core is held and fetches return NOP (32'h0).

---
 rtl/inst_memory_if.sv | 29 ++
 rtl/inst_memory.sv | 119 +++++++++++
 tb/tb_inst_memory.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_memory_if.sv
// Fetch and program-load bus of the instruction memory.
// master drives requests; slave is the memory side.
interface inst_memory_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic                  inst_enable;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [31:0]           inst_data;
  logic                  load_start;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_ready;
  logic                  load_busy;
  logic                  load_done;

  modport master (
    output inst_enable, inst_addr,
    output load_start, load_valid, load_byte,
    input  inst_data, load_ready,
    input  load_busy, load_done
  );

  modport slave (
    input  inst_enable, inst_addr,
    input  load_start, load_valid, load_byte,
    output inst_data, load_ready,
    output load_busy, load_done
  );
endinterface

// File: rtl/inst_memory.sv
// Instruction memory: registered fetch port plus
// a byte-stream program loader (count header, BE words).
module inst_memory #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  inst_memory_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BODY
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  done_q, done_d;
  logic                  busy;
  logic                  accept;
  logic                  we;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    done_d     = 1'b0;
    we         = 1'b0;
    busy       = (state_q != IDLE);
    accept     = bus.load_valid & busy;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d    = HEADER;
          byte_cnt_d = 2'd0;
          word_cnt_d = 32'd0;
          waddr_d    = '0;
          asm_d      = 32'd0;
        end
      end
      HEADER: begin
        if (accept) begin
          word_cnt_d = {word_cnt_q[23:0], bus.load_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_cnt_d == 32'd0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = BODY;
            end
          end
        end
      end
      BODY: begin
        if (accept) begin
          asm_d      = {asm_q[23:0], bus.load_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we         = 1'b1;
            waddr_d    = waddr_q + ADDR_WIDTH'(1);
            word_cnt_d = word_cnt_q - 32'd1;
            // last word: return to IDLE and flag done
            if (word_cnt_q == 32'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 32'd0;
      asm_q      <= 32'd0;
      waddr_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr_q] <= asm_d;
  end

  // fetches return NOP while a load owns the array
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= 32'h0;
    end else if (bus.inst_enable) begin
      rdata_q <= busy ? 32'h0 : mem[bus.inst_addr];
    end
  end

  assign bus.inst_data  = rdata_q;
  assign bus.load_ready = busy;
  assign bus.load_busy  = busy;
  assign bus.load_done  = done_q;
endmodule

// File: tb/tb_inst_memory.sv
// Randomized bench for inst_memory with an array
// model of memory contents and load semantics.
module tb_inst_memory;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  inst_memory_if #(.ADDR_WIDTH(AW)) bus ();

  inst_memory #(.ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [31:0] model [DEPTH];
  int n_cmp = 0;
  int n_err = 0;
  int done_pulses;
  int busy_drops;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      if (!bus.load_busy) busy_drops++;
      bus.load_valid = 1'b0;
      bus.load_byte  = 8'($urandom);
      tick();
      if (bus.load_done) done_pulses++;
    end
    if (!bus.load_busy || !bus.load_ready) busy_drops++;
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    tick();
    if (bus.load_done) done_pulses++;
    bus.load_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] w[$], input int gap);
    logic [31:0] cnt;
    done_pulses = 0;
    busy_drops  = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    cnt = 32'(w.size());
    for (int k = 3; k >= 0; k--) send_byte(cnt[8*k +: 8], gap);
    for (int j = 0; j < w.size(); j++) begin
      logic [31:0] x;
      x = w[j];
      for (int k = 3; k >= 0; k--) send_byte(x[8*k +: 8], gap);
      model[j % DEPTH] = x;
    end
    repeat (3) begin
      tick();
      if (bus.load_done) done_pulses++;
    end
  endtask

  task automatic fetch(input int a, output logic [31:0] d);
    bus.inst_enable = 1'b1;
    bus.inst_addr   = AW'(a);
    tick();
    bus.inst_enable = 1'b0;
    d = bus.inst_data;
  endtask

  task automatic test_reset();
    n_cmp += 4;
    if (bus.inst_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data got %h want 0", bus.inst_data);
    end
    if (bus.load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready got %b want 0", bus.load_ready);
    end
    if (bus.load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got %b want 0", bus.load_busy);
    end
    if (bus.load_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got %b want 0", bus.load_done);
    end
  endtask

  task automatic check_load(input string nm, input int n);
    logic [31:0] d;
    n_cmp += 3;
    if (done_pulses != 1) begin
      n_err++;
      $display("FAIL %s_done got %0d pulses want 1", nm, done_pulses);
    end
    if (busy_drops != 0) begin
      n_err++;
      $display("FAIL %s_busy got %0d drops want 0", nm, busy_drops);
    end
    if (bus.load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle got busy %b want 0", nm, bus.load_busy);
    end
    for (int a = 0; a < n; a++) begin
      fetch(a, d);
      n_cmp++;
      if (d !== model[a]) begin
        n_err++;
        $display("FAIL %s_rd[%0d] got %h want %h", nm, a, d, model[a]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    logic [31:0] d;
    w = '{32'h12345678, 32'h9ABCDEF0};
    do_load(w, 0);
    check_load("basic", 2);
    repeat (2) tick();
    d = bus.inst_data;
    n_cmp++;
    if (d !== 32'h9ABCDEF0) begin
      n_err++;
      $display("FAIL basic_hold got %h want 9abcdef0", d);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] w[$];
    w = '{32'($urandom), 32'($urandom)};
    do_load(w, 0);
    check_load("pre_gap", 2);
    w = '{32'h12345678, 32'h9ABCDEF0};
    do_load(w, 3);
    check_load("gapped", 2);
  endtask

  task automatic test_fetch_during_load();
    logic [31:0] x;
    x = 32'($urandom);
    bus.inst_enable = 1'b1;
    bus.inst_addr   = '0;
    bus.load_start  = 1'b1;
    tick();
    bus.load_start  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.load_valid = 1'b1;
      bus.load_byte  = (i < 3) ? 8'h00 :
                       (i == 3) ? 8'h01 : x[8*(7-i) +: 8];
      tick();
      n_cmp++;
      if (bus.inst_data !== 32'h0) begin
        n_err++;
        $display("FAIL busy_fetch[%0d] got %h want 0", i, bus.inst_data);
      end
    end
    bus.load_valid = 1'b0;
    model[0] = x;
    tick();
    bus.inst_enable = 1'b0;
    n_cmp++;
    if (bus.inst_data !== x) begin
      n_err++;
      $display("FAIL post_load_fetch got %h want %h", bus.inst_data, x);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] w[$];
    logic [7:0]  bytes[$];
    logic [31:0] d;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    done_pulses = 0;
    busy_drops  = 0;
    for (int i = 0; i < 3; i++) send_byte(8'h00, $urandom_range(0, 2));
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'h00;
    tick();
    bus.load_valid = 1'b0;
    n_cmp += 3;
    if (bus.load_done !== 1'b1 || done_pulses != 0) begin
      n_err++;
      $display("FAIL zero_done got %b/%0d want 1/0", bus.load_done, done_pulses);
    end
    if (bus.load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_busy got %b want 0", bus.load_busy);
    end
    tick();
    if (bus.load_done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_pulse got %b want 0", bus.load_done);
    end
    fetch(0, d);
    n_cmp++;
    if (d !== model[0]) begin
      n_err++;
      $display("FAIL zero_mem got %h want %h", d, model[0]);
    end
    // second load with stray load_start pulses in BODY
    w = '{32'($urandom), 32'($urandom)};
    bytes = '{8'h00, 8'h00, 8'h00, 8'h02};
    foreach (w[j])
      for (int k = 3; k >= 0; k--) bytes.push_back(w[j][8*k +: 8]);
    done_pulses = 0;
    busy_drops  = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      bus.load_start = (i == 5) || (i == 9);
      send_byte(bytes[i], (i == 6) ? 1 : 0);
    end
    bus.load_start = 1'b0;
    tick();
    if (bus.load_done) done_pulses++;
    model[0] = w[0];
    model[1] = w[1];
    check_load("ign_start", 2);
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w[4];
    logic [31:0] old1, d;
    logic [31:0] nw[$];
    for (int i = 0; i < 4; i++) w[i] = 32'($urandom);
    old1 = model[1];
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int k = 3; k >= 0; k--) send_byte(k == 0 ? 8'h04 : 8'h00, 0);
    for (int k = 3; k >= 0; k--) send_byte(w[0][8*k +: 8], 0);
    for (int k = 3; k >= 2; k--) send_byte(w[1][8*k +: 8], 1);
    model[0] = w[0];
    #3 rstn = 1'b0;
    #1;
    n_cmp += 3;
    if (bus.load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_busy got %b want 0", bus.load_busy);
    end
    if (bus.load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_ready got %b want 0", bus.load_ready);
    end
    if (bus.inst_data !== 32'h0) begin
      n_err++;
      $display("FAIL mid_rst_data got %h want 0", bus.inst_data);
    end
    #1 rstn = 1'b1;
    tick();
    for (int a = 0; a < 2; a++) begin
      fetch(a, d);
      n_cmp++;
      if (d !== (a == 0 ? w[0] : old1)) begin
        n_err++;
        $display("FAIL mid_rst_kept[%0d] got %h want %h", a, d,
                 a == 0 ? w[0] : old1);
      end
    end
    nw = '{32'($urandom), 32'($urandom)};
    do_load(nw, 0);
    check_load("reload", 2);
  endtask

  task automatic test_random_loads();
    logic [31:0] w[$];
    int n;
    for (int t = 0; t < 4; t++) begin
      w = {};
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) w.push_back(32'($urandom));
      do_load(w, $urandom_range(0, 2));
      check_load("rand", n);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w[$];
    w = {};
    for (int i = 0; i < DEPTH + 2; i++) w.push_back(32'($urandom));
    do_load(w, 0);
    check_load("wrap", DEPTH);
  endtask

  initial begin
    bus.inst_enable = 1'b0;
    bus.inst_addr   = '0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_byte   = 8'h00;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    #2 rstn = 1'b0;
    tick();
    test_reset();
    tick();
    rstn = 1'b1;
    tick();
    test_basic();
    test_gapped();
    test_fetch_during_load();
    test_zero_len();
    test_reset_mid_load();
    test_random_loads();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
